// File: rtl/goose_anim_seq.sv
// Spinning-goose frame sequencer: steps a frame index on divided vsync edges while spinning,
// and on stop keeps stepping until it can park on frame 0.
module goose_anim_seq #(
  parameter int NUM_FRAMES = 8,
  parameter int SPIN_LEN   = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       btn,
  input  logic [1:0] speed,
  output logic [2:0] frame_sel,
  output logic       spinning,
  output logic       beat
);

  typedef enum logic [1:0] {IDLE, SPIN, STOPPING} state_t;

  localparam logic [2:0] LAST_FRAME = 3'(NUM_FRAMES - 1);
  localparam logic [7:0] SPIN_LAST  = 8'(SPIN_LEN - 1);

  state_t     state, state_nxt;
  logic       vs_prev, s1, s2, btn_prev;
  logic       vs_edge, btn_edge, step, beat_nxt;
  logic [2:0] div_cnt, div_nxt, frame_nxt;
  logic [7:0] spin_cnt, spin_nxt;
  logic [3:0] period_m1;

  assign vs_edge   = vsync & ~vs_prev;
  assign btn_edge  = s2 & ~btn_prev;
  assign period_m1 = (4'd8 >> speed) - 4'd1;

  // vs_prev resets high so a vsync already high at release is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev  <= 1'b1;
      s1       <= 1'b0;
      s2       <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      vs_prev  <= vsync;
      s1       <= btn;
      s2       <= s1;
      btn_prev <= s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      frame_sel <= 3'd0;
      div_cnt   <= 3'd0;
      spin_cnt  <= 8'd0;
      spinning  <= 1'b0;
      beat      <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_sel <= frame_nxt;
      div_cnt   <= div_nxt;
      spin_cnt  <= spin_nxt;
      spinning  <= (state_nxt != IDLE);
      beat      <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_nxt = frame_sel;
    div_nxt   = div_cnt;
    spin_nxt  = spin_cnt;
    step      = 1'b0;

    // Parking on frame 0 while stopping suppresses the step unless a press re-arms the spin
    if (state != IDLE && vs_edge && !(state == STOPPING && frame_sel == 3'd0 && !btn_edge)) begin
      if ({1'b0, div_cnt} >= period_m1) begin
        div_nxt = 3'd0;
        step    = 1'b1;
      end else begin
        div_nxt = div_cnt + 3'd1;
      end
    end

    if (step) frame_nxt = (frame_sel == LAST_FRAME) ? 3'd0 : frame_sel + 3'd1;
    beat_nxt = step && (frame_sel == LAST_FRAME);

    case (state)
      IDLE: begin
        div_nxt = 3'd0;
        if (btn_edge) begin
          state_nxt = SPIN;
          spin_nxt  = 8'd0;
        end
      end
      SPIN: begin
        if (vs_edge) spin_nxt = spin_cnt + 8'd1;
        if (btn_edge) state_nxt = STOPPING;
        else if (vs_edge && spin_cnt == SPIN_LAST) state_nxt = STOPPING;
      end
      STOPPING: begin
        if (btn_edge) begin
          state_nxt = SPIN;
          spin_nxt  = 8'd0;
        end else if (frame_sel == 3'd0) begin
          state_nxt = IDLE;
          div_nxt   = 3'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/goose_anim_seq.md
GOOSE_ANIM_SEQ -- requirements
Module: goose_anim_seq

Interface
REQ-001 Parameter NUM_FRAMES, default 8: number of animation frames; legal range 2..8.
REQ-002 Parameter SPIN_LEN, default 240: vsync edges per spin session before auto-stop; legal range 1..255.
REQ-003 clk  input  1  pixel clock, same domain as the VGA timing generator.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 vsync  input  1  vertical sync level from the timing generator; a frame event is its 0->1 transition.
REQ-006 btn  input  1  asynchronous spin button (ui_in[0]); the block synchronizes it internally.
REQ-007 speed  input  2  step-period select (ui_in[2:1]); quasi-static.
REQ-008 frame_sel  output  3  current frame index, 0..NUM_FRAMES-1, fed to the frame LUT select.
REQ-009 spinning  output  1  high whenever state != IDLE.
REQ-010 beat  output  1  one-cycle pulse when frame_sel wraps from NUM_FRAMES-1 to 0.

Function
REQ-011 The frame event vs_edge SHALL be vsync & ~vs_prev, where vs_prev is vsync registered every cycle.
REQ-012 btn SHALL pass through a two-flop synchronizer (s1, s2); btn_edge SHALL be s2 & ~btn_prev, with btn_prev being s2 registered.
  - btn_edge asserts exactly 2 cycles after btn is first sampled high.
  - At most one btn_edge per press.
REQ-013 Step period P SHALL be 8 >> speed (speed 0..3 -> 8, 4, 2, 1 frame events per step).
REQ-014 The 3-bit div_cnt SHALL increment on each vs_edge while state is SPIN or STOPPING.
  - When div_cnt >= P-1 on vs_edge: div_cnt <- 0 and a step occurs.
  - Using >= means a speed change mid-spin never stalls.
REQ-015 A step SHALL advance frame_sel by 1, wrapping NUM_FRAMES-1 -> 0; beat SHALL assert in the cycle following the wrap edge.
REQ-016 The state machine SHALL have states IDLE, SPIN and STOPPING.
REQ-017 IDLE behaviour:
  - frame_sel holds, div_cnt = 0, no steps.
  - btn_edge -> SPIN, with div_cnt <- 0 and spin_cnt <- 0.
REQ-018 SPIN behaviour:
  - spin_cnt (8-bit) increments on each vs_edge.
  - btn_edge -> STOPPING.
  - vs_edge with spin_cnt == SPIN_LEN-1 -> STOPPING.
  - btn_edge takes priority if both occur in the same cycle.
REQ-019 STOPPING behaviour:
  - Steps continue per REQ-014.
  - When frame_sel == 0 at a clock edge: -> IDLE, with no step that cycle and div_cnt <- 0.
  - btn_edge (checked first) -> SPIN, with spin_cnt <- 0 and frame_sel retained.
REQ-020 A step and a state transition SHALL take effect on the same clock edge when coincident; the step is evaluated against the pre-transition state.
REQ-021 Entering STOPPING from SPIN with frame_sel already 0 SHALL reach IDLE on the next clock edge; this shows as exactly one cycle of STOPPING.
REQ-022 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-023 While reset is high, all of the following SHALL hold asynchronously:
  - state = IDLE, frame_sel = 0, spinning = 0, beat = 0.
  - div_cnt = 0, spin_cnt = 0.
  - s1, s2 and btn_prev = 0.
REQ-024 vs_prev SHALL reset to 1, so a vsync already high at reset release produces no spurious vs_edge.
REQ-025 Reset asserted mid-spin SHALL abort immediately to the REQ-023 values; after release, the block requires a fresh btn_edge to spin.

Verification
REQ-026 The bench SHALL cover these directed scenarios (defaults NUM_FRAMES=8, SPIN_LEN=240, unless stated):
  - S1: reset, speed=3, one btn press, 20 vsync pulses -> spinning=1 two cycles after the press; frame_sel sequence 1..7,0,1..; beat pulses once per 8 vsyncs.
  - S2: speed=0, SPIN_LEN=240 -> one step per 8 vsyncs; after vsync 240, STOPPING continues to frame_sel=0, then spinning=0.
  - S3: speed=2, second btn press when frame_sel=5 -> steps continue 6, 7, 0; IDLE on reaching 0; beat pulses once.
  - S4: btn press in STOPPING at frame_sel=3 -> returns to SPIN with frame_sel=3 kept; spin_cnt restarts (auto-stop 240 vsyncs later).
  - S5: vsync held high across reset release -> no step and no vs_edge until vsync goes 0 then 1.
  - S6: reset pulsed while frame_sel=6 in SPIN -> frame_sel=0 and spinning=0 immediately; vsync pulses without a btn press produce no steps.
